// File: rtl/spi_mem_arbiter.sv
// rtl/spi_mem_arbiter.sv - fetch/data port arbiter onto a shared SPI flash/PSRAM bus
// Optional macro SPI_ARB_DATA_PRIORITY_EN: data port wins every tie instead of round-robin.
module spi_mem_arbiter (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        fetch_req_in,
    input  logic [23:0] fetch_addr_in,
    output logic        fetch_ready_out,
    output logic [7:0]  fetch_data_out,
    input  logic        data_req_in,
    input  logic        data_we_in,
    input  logic [23:0] data_addr_in,
    input  logic [7:0]  data_wdata_in,
    output logic        data_ready_out,
    output logic [7:0]  data_rdata_out,
    output logic        sclk_out,
    output logic        flash_cs_out,
    output logic        psram_cs_out,
    output logic        mosi_out,
    input  logic        miso_in,
    output logic        busy_out
);

    typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, DONE} state_t;

    state_t      state, state_next;
    logic [6:0]  cnt;
    logic        grant_data;
    logic        last_grant_data;
    logic        op_we;
    logic        tgt_psram;
    logic [39:0] frame;
    logic [7:0]  rx_shift;
    logic        pick_data;
    logic        cs_active;
    logic [5:0]  bit_idx;

    always_comb begin
        pick_data = 1'b0;
        if (data_req_in && !fetch_req_in) begin
            pick_data = 1'b1;
        end else if (data_req_in && fetch_req_in) begin
`ifdef SPI_ARB_DATA_PRIORITY_EN
            pick_data = 1'b1;
`else
            pick_data = !last_grant_data;
`endif
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (fetch_req_in || data_req_in) begin
                    // Flash writes are not supported on the bus; complete them without a transfer.
                    if (pick_data && data_we_in && !data_addr_in[23])
                        state_next = DONE;
                    else
                        state_next = CS_SETUP;
                end
            end
            CS_SETUP: state_next = SHIFT;
            SHIFT:    if (cnt == 7'd79) state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        cs_active       = (state == CS_SETUP) || (state == SHIFT);
        bit_idx         = 6'd39 - {1'b0, cnt[6:2], cnt[1]};
        flash_cs_out    = !(cs_active && !tgt_psram);
        psram_cs_out    = !(cs_active && tgt_psram);
        sclk_out        = (state == SHIFT) && cnt[0];
        mosi_out        = cs_active ? frame[bit_idx] : 1'b0;
        fetch_ready_out = (state == DONE) && !grant_data;
        data_ready_out  = (state == DONE) && grant_data;
        busy_out        = (state != IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state           <= IDLE;
            cnt             <= 7'd0;
            grant_data      <= 1'b0;
            last_grant_data <= 1'b1;
            op_we           <= 1'b0;
            tgt_psram       <= 1'b0;
            frame           <= 40'd0;
            rx_shift        <= 8'd0;
            fetch_data_out  <= 8'd0;
            data_rdata_out  <= 8'd0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (fetch_req_in || data_req_in) begin
                        grant_data      <= pick_data;
                        last_grant_data <= pick_data;
                        cnt             <= 7'd0;
                        rx_shift        <= 8'd0;
                        if (pick_data) begin
                            op_we     <= data_we_in;
                            tgt_psram <= data_addr_in[23];
                            frame     <= {data_we_in ? 8'h02 : 8'h03, data_addr_in,
                                          data_we_in ? data_wdata_in : 8'h00};
                        end else begin
                            op_we     <= 1'b0;
                            tgt_psram <= 1'b0;
                            frame     <= {8'h03, fetch_addr_in, 8'h00};
                        end
                    end
                end
                SHIFT: begin
                    cnt <= cnt + 7'd1;
                    // Data bits occupy counts 64..79; the odd counts are the SCLK-high halves.
                    if (cnt[0] && cnt >= 7'd64)
                        rx_shift <= {rx_shift[6:0], miso_in};
                    if (cnt == 7'd79 && !op_we) begin
                        if (grant_data)
                            data_rdata_out <= {rx_shift[6:0], miso_in};
                        else
                            fetch_data_out <= {rx_shift[6:0], miso_in};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// tb/tb_spi_mem_arbiter.sv - scoreboard bench for spi_mem_arbiter with a SPI slave model
module tb_spi_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_in;
    logic        fetch_req_in;
    logic [23:0] fetch_addr_in;
    logic        fetch_ready_out;
    logic [7:0]  fetch_data_out;
    logic        data_req_in;
    logic        data_we_in;
    logic [23:0] data_addr_in;
    logic [7:0]  data_wdata_in;
    logic        data_ready_out;
    logic [7:0]  data_rdata_out;
    logic        sclk_out, flash_cs_out, psram_cs_out, mosi_out;
    logic        miso_in = 1'b0;
    logic        busy_out;

    spi_mem_arbiter dut (
        .clk_in(clk), .reset_in(reset_in),
        .fetch_req_in(fetch_req_in), .fetch_addr_in(fetch_addr_in),
        .fetch_ready_out(fetch_ready_out), .fetch_data_out(fetch_data_out),
        .data_req_in(data_req_in), .data_we_in(data_we_in), .data_addr_in(data_addr_in),
        .data_wdata_in(data_wdata_in), .data_ready_out(data_ready_out),
        .data_rdata_out(data_rdata_out), .sclk_out(sclk_out), .flash_cs_out(flash_cs_out),
        .psram_cs_out(psram_cs_out), .mosi_out(mosi_out), .miso_in(miso_in),
        .busy_out(busy_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        port;
        logic [39:0] frame;
        int          bits;
        int          cs_kind;
        int          cs_cycles;
        int          lat;
        logic [7:0]  miso;
        logic [7:0]  fdata;
        logic [7:0]  drdata;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] m_fdata = 8'h00;
    logic [7:0] m_drdata = 8'h00;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic port, input logic we, input logic [23:0] addr,
                            input logic [7:0] wdata, input logic [7:0] miso);
        exp_t e;
        logic bypass;
        bypass      = port && we && !addr[23];
        e.port      = port;
        e.frame     = bypass ? 40'd0 : {we ? 8'h02 : 8'h03, addr, we ? wdata : 8'h00};
        e.bits      = bypass ? 0 : 40;
        e.cs_kind   = bypass ? 0 : ((port && addr[23]) ? 2 : 1);
        e.cs_cycles = bypass ? 0 : 81;
        e.lat       = bypass ? 0 : 81;
        e.miso      = miso;
        if (!we) begin
            if (port) m_drdata = miso;
            else      m_fdata  = miso;
        end
        e.fdata  = m_fdata;
        e.drdata = m_drdata;
        exp_q.push_back(e);
    endtask

    // Bus monitor and SPI slave, evaluated mid-cycle.
    int          cyc = 0;
    int          busy_start = 0;
    int          bit_cnt = 0;
    int          cs_kind = 0;
    int          cs_low_cnt = 0;
    int          cs_high_run = 2;
    logic [39:0] cap_frame = 40'd0;
    logic        prev_busy = 1'b0, prev_sclk = 1'b0, prev_cs_low = 1'b0, prev_mosi = 1'b0;
    logic        ever_low = 1'b0;
    logic        cs_overlap = 1'b0, mosi_bad = 1'b0, gap_bad = 1'b0;

    always @(negedge clk) begin
        logic cs_low;
        exp_t e;
        cyc++;
        cs_low = !flash_cs_out || !psram_cs_out;
        if (!flash_cs_out && !psram_cs_out) cs_overlap = 1'b1;
        if (busy_out && !prev_busy) begin
            busy_start = cyc;
            cs_kind    = 0;
            bit_cnt    = 0;
            cap_frame  = 40'd0;
            cs_low_cnt = 0;
        end
        if (cs_low && !prev_cs_low) begin
            if (ever_low && cs_high_run < 2) gap_bad = 1'b1;
            ever_low   = 1'b1;
            cs_kind    = !psram_cs_out ? 2 : 1;
            bit_cnt    = 0;
            cap_frame  = 40'd0;
            cs_low_cnt = 0;
        end
        if (cs_low) begin
            cs_low_cnt++;
            cs_high_run = 0;
        end else begin
            cs_high_run++;
        end
        if (sclk_out && mosi_out !== prev_mosi) mosi_bad = 1'b1;
        if (sclk_out && !prev_sclk) begin
            cap_frame = {cap_frame[38:0], mosi_out};
            bit_cnt++;
        end
        if (!sclk_out) begin
            if (cs_low && bit_cnt >= 32 && bit_cnt < 40 && exp_q.size() > 0)
                miso_in = exp_q[0].miso[39 - bit_cnt];
            else
                miso_in = 1'b0;
        end
        if (fetch_ready_out || data_ready_out) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_ready", {fetch_ready_out, data_ready_out}, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("ready_onehot", fetch_ready_out ^ data_ready_out, 1);
                check_eq("ready_port", data_ready_out, e.port);
                check_eq("bit_count", bit_cnt, e.bits);
                check_eq("mosi_frame", cap_frame, e.frame);
                check_eq("cs_target", cs_kind, e.cs_kind);
                check_eq("cs_low_cycles", cs_low_cnt, e.cs_cycles);
                check_eq("ready_latency", cyc - busy_start, e.lat);
                check_eq("fetch_data", fetch_data_out, e.fdata);
                check_eq("data_rdata", data_rdata_out, e.drdata);
            end
        end
        prev_busy   = busy_out;
        prev_sclk   = sclk_out;
        prev_cs_low = cs_low;
        prev_mosi   = mosi_out;
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset_in     = 1'b1;
        fetch_req_in = 1'b0;
        data_req_in  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_in = 1'b0;
        m_fdata  = 8'h00;
        m_drdata = 8'h00;
    endtask

    task automatic run_one(input logic port, input logic we, input logic [23:0] addr,
                           input logic [7:0] wdata, input logic [7:0] miso);
        bit done;
        push_exp(port, we, addr, wdata, miso);
        @(posedge clk); #1;
        if (port) begin
            data_req_in   = 1'b1;
            data_we_in    = we;
            data_addr_in  = addr;
            data_wdata_in = wdata;
        end else begin
            fetch_req_in  = 1'b1;
            fetch_addr_in = addr;
        end
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk); #1;
            if (port ? data_ready_out : fetch_ready_out) done = 1'b1;
        end
        if (!done) check_eq("timeout_single", port ? data_ready_out : fetch_ready_out, 1);
        fetch_req_in = 1'b0;
        data_req_in  = 1'b0;
        data_addr_in = 24'h5A5A5A;
        fetch_addr_in = 24'hA5A5A5;
        @(posedge clk); #1;
    endtask

    initial begin
        int n_rdy;
        reset_in      = 1'b1;
        fetch_req_in  = 1'b0;
        fetch_addr_in = 24'd0;
        data_req_in   = 1'b0;
        data_we_in    = 1'b0;
        data_addr_in  = 24'd0;
        data_wdata_in = 8'd0;
        do_reset();

        check_eq("rst_flash_cs", flash_cs_out, 1);
        check_eq("rst_psram_cs", psram_cs_out, 1);
        check_eq("rst_sclk", sclk_out, 0);
        check_eq("rst_mosi", mosi_out, 0);
        check_eq("rst_ready", {fetch_ready_out, data_ready_out}, 0);
        check_eq("rst_data", {fetch_data_out, data_rdata_out}, 0);
        check_eq("rst_busy", busy_out, 0);

        run_one(1'b0, 1'b0, 24'h000123, 8'h00, 8'hA5);
        run_one(1'b1, 1'b1, 24'h800010, 8'h5A, 8'hFF);
        run_one(1'b1, 1'b0, 24'h812345, 8'h00, 8'h3C);
        run_one(1'b1, 1'b0, 24'h000456, 8'h00, 8'hC3);
        run_one(1'b1, 1'b1, 24'h000010, 8'h77, 8'hFF);
        run_one(1'b0, 1'b0, 24'h8000F1, 8'h00, 8'h96);

        do_reset();
`ifdef SPI_ARB_DATA_PRIORITY_EN
        push_exp(1'b1, 1'b0, 24'h800020, 8'h00, 8'h11);
        push_exp(1'b1, 1'b0, 24'h800020, 8'h00, 8'h22);
        push_exp(1'b1, 1'b0, 24'h800020, 8'h00, 8'h33);
        push_exp(1'b1, 1'b0, 24'h800020, 8'h00, 8'h44);
`else
        push_exp(1'b0, 1'b0, 24'h0000F1, 8'h00, 8'h11);
        push_exp(1'b1, 1'b0, 24'h800020, 8'h00, 8'h22);
        push_exp(1'b0, 1'b0, 24'h0000F1, 8'h00, 8'h33);
        push_exp(1'b1, 1'b0, 24'h800020, 8'h00, 8'h44);
`endif
        fetch_req_in  = 1'b1;
        fetch_addr_in = 24'h0000F1;
        data_req_in   = 1'b1;
        data_we_in    = 1'b0;
        data_addr_in  = 24'h800020;
        n_rdy = 0;
        for (int i = 0; i < 1000 && n_rdy < 4; i++) begin
            @(posedge clk); #1;
            if (fetch_ready_out || data_ready_out) n_rdy++;
        end
        check_eq("tie_grants_done", n_rdy, 4);
        fetch_req_in = 1'b0;
        data_req_in  = 1'b0;
        @(posedge clk); #1;

        data_req_in  = 1'b1;
        data_we_in   = 1'b0;
        data_addr_in = 24'h800100;
        for (int i = 0; i < 50 && !busy_out; i++) begin
            @(posedge clk); #1;
        end
        check_eq("abort_busy_start", busy_out, 1);
        repeat (39) @(posedge clk);
        #1;
        reset_in    = 1'b1;
        data_req_in = 1'b0;
        @(posedge clk); #1;
        check_eq("abort_flash_cs", flash_cs_out, 1);
        check_eq("abort_psram_cs", psram_cs_out, 1);
        check_eq("abort_sclk", sclk_out, 0);
        check_eq("abort_ready", {fetch_ready_out, data_ready_out}, 0);
        check_eq("abort_busy", busy_out, 0);
        reset_in = 1'b0;
        m_fdata  = 8'h00;
        m_drdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        run_one(1'b0, 1'b0, 24'h00ABCD, 8'h00, 8'h5E);

        repeat (4) @(posedge clk);
        #1;
        check_eq("cs_overlap", cs_overlap, 0);
        check_eq("mosi_changed_sclk_high", mosi_bad, 0);
        check_eq("cs_gap", gap_bad, 0);
        check_eq("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 0x0 expected 0x1");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_mem_arbiter.md
SPI_MEM_ARBITER -- requirements
Module: spi_mem_arbiter

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all other ports are synchronous to clk_in.
REQ-002 clk_in  input  1  system clock.
REQ-003 reset_in  input  1  synchronous active-high reset.
REQ-004 fetch_req_in  input  1  instruction-fetch read request, level, held until fetch_ready_out.
REQ-005 fetch_addr_in  input  24  flash byte address for fetch.
REQ-006 fetch_ready_out  output  1  one-cycle pulse: fetch complete, fetch_data_out valid.
REQ-007 fetch_data_out  output  8  last byte read for fetch port.
REQ-008 data_req_in  input  1  data-access request, level, held until data_ready_out.
REQ-009 data_we_in  input  1  1 = write, 0 = read.
REQ-010 data_addr_in  input  24  bit 23 = 1 selects PSRAM, 0 selects flash.
REQ-011 data_wdata_in  input  8  write byte.
REQ-012 data_ready_out  output  1  one-cycle pulse: data access complete.
REQ-013 data_rdata_out  output  8  last byte read for data port.
REQ-014 sclk_out, flash_cs_out, psram_cs_out, mosi_out  output  1 each  shared SPI bus; CS active-low.
REQ-015 miso_in  input  1  shared SPI MISO.
REQ-016 busy_out  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement states IDLE, CS_SETUP, SHIFT, DONE.
REQ-018 IDLE: no request -> stay; any request -> latch winner's op/addr/wdata/target, go CS_SETUP (grant cycle = cycle 0).
REQ-019 Tie (both requests in same IDLE cycle): round-robin, grant port not granted last; single requester always granted.
REQ-020 CS_SETUP (cycle 1): target CS low, sclk_out 0, mosi_out = first command bit.
REQ-021 SHIFT (cycles 2-81): 40 bits MSB-first = command (0x03 read, 0x02 write), 24-bit address, 8 data bits; SPI mode 0, 2 clk_in cycles per bit, SCLK low cycle then high cycle.
REQ-022 mosi_out SHALL change only in SCLK-low cycles; miso_in sampled on the clk_in edge ending each SCLK-high cycle of the 8 data bits.
REQ-023 mosi_out during read data bits SHALL be 0.
REQ-024 DONE (cycle 82): both CS high, sclk_out 0, granted port's ready pulses, read byte copied to that port's data output; next state IDLE.
REQ-025 Fetch always targets flash; data targets per data_addr_in[23].
REQ-026 Data write with addr[23]=0 (flash): no CS asserted, no SCLK activity; SHALL go IDLE -> DONE directly, data_ready_out in cycle 1.
REQ-027 Writes SHALL NOT modify data_rdata_out; fetch_data_out changes only on fetch completion.
REQ-028 Request deassertion or input changes after grant SHALL be ignored until DONE.
REQ-029 At most one CS low at any time; CS high for at least 2 cycles between transactions.
REQ-030 Request arriving during a transaction SHALL wait; granted in the IDLE cycle after DONE.

Reset
REQ-031 reset_in high SHALL, on the next edge, from any state: state IDLE, flash_cs_out=1, psram_cs_out=1, sclk_out=0, mosi_out=0, both ready=0, both data outputs 0x00, busy_out=0, last-grant = data (fetch wins first tie).
REQ-032 Reset mid-SHIFT SHALL abort without ready pulse.

Configuration
REQ-033 Macro SPI_ARB_DATA_PRIORITY_EN: defined -> data port wins every tie (fixed priority); undefined -> round-robin per REQ-019.

Verification
REQ-034 Fetch only, addr 0x000123, flash drives 0xA5 -> MOSI 0x03,0x00,0x01,0x23; flash_cs low cycles 1-81; fetch_ready_out pulse cycle 82; fetch_data_out=0xA5.
REQ-035 Data write addr 0x800010 data 0x5A -> psram_cs low, MOSI 0x02,0x80,0x00,0x10,0x5A; data_ready_out cycle 82; data_rdata_out unchanged.
REQ-036 Both requests held continuously after reset -> grants alternate fetch, data, fetch, data (macro undefined); data, data, ... granted data when macro defined and data held.
REQ-037 Data write addr 0x000010 -> no CS/SCLK activity; data_ready_out one cycle after grant.
REQ-038 reset_in asserted at cycle 40 of a PSRAM read -> next cycle both CS high, sclk 0, no ready pulse; new fetch afterwards completes normally.
